// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub: multi-cycle adder/subtractor, DIGIT bits per clock,
// LSB digit first, with an internal accumulator and registered flags.
module digit_serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             subtract,
    input  logic             accumulate,
    input  logic             acc_clear,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             done,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [DIGIT:0]         digit_sum;
    logic [WIDTH+DIGIT-1:0] sum_wide;
    logic [WIDTH-1:0]       sum_next;
    logic [WIDTH-1:0]       first_op;
    logic [WIDTH-1:0]       b_prime;
    logic                   last_digit;
    logic                   ovf_calc;

    // One digit of the ripple: operand LSB digits plus the running carry.
    always_comb begin
        digit_sum = {1'b0, op_a_q[DIGIT-1:0]}
                  + {1'b0, op_b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        // Wide concat keeps the shift legal when DIGIT == WIDTH.
        sum_wide   = {digit_sum[DIGIT-1:0], sum_q};
        sum_next   = sum_wide[WIDTH+DIGIT-1:DIGIT];
        last_digit = (cnt_q == LAST);
        ovf_calc   = (a_msb_q == b_msb_q) &&
                     (sum_next[WIDTH-1] != a_msb_q);
    end

    // Operand selection at acceptance; a same-edge clear forces a zero
    // accumulator operand.
    always_comb begin
        if (accumulate) begin
            first_op = acc_clear ? '0 : acc_q;
        end else begin
            first_op = A;
        end
        b_prime = subtract ? ~B : B;
    end

    // Next-state logic for the sequencer, datapath and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (acc_clear) begin
                    acc_d = '0;
                end
                if (start) begin
                    op_a_d  = first_op;
                    op_b_d  = b_prime;
                    a_msb_d = first_op[WIDTH-1];
                    b_msb_d = b_prime[WIDTH-1];
                    carry_d = subtract;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                op_a_d  = op_a_q >> DIGIT;
                op_b_d  = op_b_q >> DIGIT;
                sum_d   = sum_next;
                carry_d = digit_sum[DIGIT];
                if (last_digit) begin
                    cnt_d   = '0;
                    res_d   = sum_next;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = ovf_calc;
                    zero_d  = (sum_next == '0);
                    acc_d   = sum_next;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and digit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand shift registers, partial sum and carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Accumulator, written on clear and on every completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Visible result, flags and the completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            res_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            done_q <= done_d;
        end
    end

    assign Result   = res_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign done     = done_q;
    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// tb_digit_serial_add_sub: directed 8-bit vectors plus exhaustive 4-bit
// sweeps at DIGIT = 1, 2 and 4 against a signed/unsigned reference model.
module tb_digit_serial_add_sub;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       acc = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] res;
    logic       cout, ovf, zero, done, busy, in_ready;

    logic [2:0] st4 = '0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       sub4 = 1'b0;
    logic [2:0] rdy4, cout4, ovf4, zero4, done4, busy4;
    logic [3:0] res4 [3];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    digit_serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
        .A(a), .B(b), .subtract(sub), .accumulate(acc),
        .acc_clear(clr), .Result(res), .Cout(cout),
        .Overflow(ovf), .Zero(zero), .done(done), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_w4
        digit_serial_add_sub #(.WIDTH(4), .DIGIT(1 << g)) u_w4 (
            .clk(clk), .reset(reset), .start(st4[g]),
            .in_ready(rdy4[g]), .A(a4), .B(b4), .subtract(sub4),
            .accumulate(1'b0), .acc_clear(1'b0), .Result(res4[g]),
            .Cout(cout4[g]), .Overflow(ovf4[g]), .Zero(zero4[g]),
            .done(done4[g]), .busy(busy4[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, tb_,
                       input logic ts, tacc, tclr,
                       input logic [7:0] er, input logic ec, eo, ez);
        int k;
        @(negedge clk);
        a = ta; b = tb_; sub = ts; acc = tacc; clr = tclr; start = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        k = 1;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".lat"}, k, 3);
        chk({tag, ".res"}, res, er);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".zero"}, zero, ez);
        @(negedge clk);
        chk({tag, ".done_lo"}, done, 0);
        chk({tag, ".rdy"}, in_ready, 1);
    endtask

    task automatic op4(input int idx, input int ta, tb_, input logic ts);
        int k, sa, sb, t, er, lat;
        logic ec, eo;
        string tag;
        tag = $sformatf("w4d%0d_%0h%s%0h", 1 << idx, ta, ts ? "-" : "+", tb_);
        sa = (ta >= 8) ? ta - 16 : ta;
        sb = (tb_ >= 8) ? tb_ - 16 : tb_;
        t  = ts ? sa - sb : sa + sb;
        eo = (t > 7) || (t < -8);
        er = (ts ? ta - tb_ : ta + tb_) & 15;
        ec = ts ? (ta >= tb_) : (ta + tb_ > 15);
        lat = (4 >> idx) + 1;
        @(negedge clk);
        a4 = 4'(ta); b4 = 4'(tb_); sub4 = ts; st4[idx] = 1'b1;
        @(negedge clk);
        st4[idx] = 1'b0;
        k = 1;
        while (!done4[idx] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".lat"}, k, lat);
        chk({tag, ".res"}, res4[idx], er);
        chk({tag, ".cout"}, cout4[idx], ec);
        chk({tag, ".ovf"}, ovf4[idx], eo);
        chk({tag, ".zero"}, zero4[idx], er == 0);
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        logic [7:0] cap;

        repeat (3) @(negedge clk);
        chk("rst.res", res, 0);
        chk("rst.flags", {cout, ovf, zero, done, busy}, 0);
        chk("rst.rdy", in_ready, 1);
        reset = 1'b0;

        op8("add", 8'h3C, 8'h14, 0, 0, 0, 8'h50, 0, 0, 0);
        op8("sub_neg", 8'h05, 8'h07, 1, 0, 0, 8'hFE, 0, 0, 0);
        op8("sub_eq", 8'h07, 8'h07, 1, 0, 0, 8'h00, 1, 0, 1);
        op8("ovf_add", 8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0);
        op8("ovf_sub", 8'h80, 8'h01, 1, 0, 0, 8'h7F, 1, 1, 0);
        op8("wrap", 8'hFF, 8'h01, 0, 0, 0, 8'h00, 1, 0, 1);

        op8("acc1", 8'hAA, 8'h10, 0, 1, 1, 8'h10, 0, 0, 0);
        op8("acc2", 8'hAA, 8'h10, 0, 1, 0, 8'h20, 0, 0, 0);
        op8("acc3", 8'hAA, 8'h10, 0, 1, 0, 8'h30, 0, 0, 0);
        op8("acc_sub", 8'hAA, 8'h30, 1, 1, 0, 8'h00, 1, 0, 1);

        // start held through RUN and DONE, operand A changed mid-flight
        @(negedge clk);
        a = 8'h21; b = 8'h12; sub = 1'b0; acc = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hFF;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                cap = res;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        chk("robust.ndone", ndone, 1);
        chk("robust.res", cap, 8'h33);

        op8("pre_rst", 8'h80, 8'h01, 1, 0, 0, 8'h7F, 1, 1, 0);
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b0; acc = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid.busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst.res", res, 0);
        chk("mid_rst.flags", {cout, ovf, zero, done, busy}, 0);
        chk("mid_rst.rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        op8("post_rst", 8'h77, 8'h05, 0, 1, 0, 8'h05, 0, 0, 0);

        for (int idx = 0; idx < 3; idx++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int s = 0; s < 2; s++)
                        op4(idx, x, y, s[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
